// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue/execute interface.
//   alu_op_e        4-bit ALUOp encodings understood by the execute-stage ALU
//   OPC_*           RV32I major opcodes recognised by the issue stage
//   issue_payload_t registered payload handed from issue to execute
package alu_pkg;

  localparam int unsigned ALU_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e               alu_op;
    logic [ALU_XLEN-1:0]   op_a;
    logic [ALU_XLEN-1:0]   op_b;
    logic                  illegal;
    logic                  br_negate;
  } issue_payload_t;

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: generic 2-entry (main + skid) valid/ready buffer.
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake; in_ready comes straight from a flop
//   in_data           upstream payload of type T
//   out_valid/out_ready downstream handshake
//   out_data          payload held in the main entry
// Order is strict FIFO; skid is only ever occupied while main is occupied.
module skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     main_q;
  T     skid_q;
  logic main_full;
  logic skid_full;
  logic accept;
  logic drain;

  assign accept = in_valid && !skid_full;
  assign drain  = main_full && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_full <= 1'b0;
      skid_full <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      if (!main_full) begin
        // skid is necessarily empty here
        if (accept) begin
          main_q    <= in_data;
          main_full <= 1'b1;
        end
      end else if (!drain) begin
        // main stalled: a new arrival parks in skid, which closes in_ready
        if (accept) begin
          skid_q    <= in_data;
          skid_full <= 1'b1;
        end
      end else if (skid_full) begin
        // older skid entry moves forward; no accept is possible this cycle
        main_q    <= skid_q;
        skid_full <= 1'b0;
      end else if (accept) begin
        main_q <= in_data;
      end else begin
        main_full <= 1'b0;
      end
    end
  end

  assign in_ready  = !skid_full;
  assign out_valid = main_full;
  assign out_data  = main_q;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode into ALUOp / operand A / operand B, registered
// toward the execute-stage ALU behind a 2-entry skid buffer.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   upstream handshake (in_ready registered)
//   instr, pc            instruction word and its address
//   rs1_data, rs2_data   register-file read values
//   out_valid, out_ready downstream handshake toward the ALU
//   alu_op, op_a, op_b   ALU controls and operands
//   illegal              instruction not decodable
//   br_negate            branch condition is the inverse of the ALU result
// Parameters: XLEN (must be 32), ZERO_ILLEGAL (zero operands of illegal instrs).
// Build option: define ALU_ISSUE_BRANCH_EN to decode conditional branches;
// otherwise BRANCH is illegal and br_negate is always 0.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ZERO_ILLEGAL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            illegal,
  output logic            br_negate
);

  if (XLEN != 32) begin : g_xlen_check
    $error("alu_issue_stage: only XLEN=32 is supported");
  end

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            b30;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] shamt;
  logic            legal;
  issue_payload_t  dec;
  issue_payload_t  pl_out;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign b30    = instr[30];
  assign i_imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign s_imm  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm  = {instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

  always_comb begin
    dec           = '0;
    dec.alu_op    = ALU_ADD;
    dec.op_a      = rs1_data;
    dec.op_b      = rs2_data;
    legal         = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.alu_op = alu_op_e'({b30, f3});
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        dec.op_b = i_imm;
        case (f3)
          3'b001: begin
            dec.alu_op = ALU_SLL;
            dec.op_b   = shamt;
            legal      = (f7 == F7_BASE);
          end
          3'b101: begin
            dec.alu_op = b30 ? ALU_SRA : ALU_SRL;
            dec.op_b   = shamt;
            legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          // instr[30] is immediate data here, never an op modifier
          default: dec.alu_op = alu_op_e'({1'b0, f3});
        endcase
      end
      OPC_LUI: begin
        dec.op_a = '0;
        dec.op_b = u_imm;
      end
      OPC_AUIPC: begin
        dec.op_a = pc;
        dec.op_b = u_imm;
      end
      OPC_LOAD:  dec.op_b = i_imm;
      OPC_STORE: dec.op_b = s_imm;
`ifdef ALU_ISSUE_BRANCH_EN
      OPC_BRANCH: begin
        // f3[0] selects the inverted form (BNE/BGE/BGEU vs BEQ/BLT/BLTU);
        // for BEQ the ALU does SUB, so "equal" is a zero result -> negate
        case (f3[2:1])
          2'b00: dec.alu_op = ALU_SUB;
          2'b10: dec.alu_op = ALU_SLT;
          2'b11: dec.alu_op = ALU_SLTU;
          default: legal = 1'b0;
        endcase
        dec.br_negate = (f3 == 3'b000) || (f3 == 3'b101) || (f3 == 3'b111);
      end
`endif
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.alu_op    = ALU_ADD;
      dec.illegal   = 1'b1;
      dec.br_negate = 1'b0;
      if (ZERO_ILLEGAL != 0) begin
        dec.op_a = '0;
        dec.op_b = '0;
      end else begin
        dec.op_a = rs1_data;
        dec.op_b = rs2_data;
      end
    end
  end

  skid_buffer #(
    .T(issue_payload_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out)
  );

  assign alu_op    = pl_out.alu_op;
  assign op_a      = pl_out.op_a;
  assign op_b      = pl_out.op_b;
  assign illegal   = pl_out.illegal;
  assign br_negate = pl_out.br_negate;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        illegal;
  logic        br_negate;

  int checks = 0;
  int failures = 0;

  alu_issue_stage #(
    .XLEN(32),
    .ZERO_ILLEGAL(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .illegal   (illegal),
    .br_negate (br_negate)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
    logic        neg;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v;
    instr    = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".in_ready"},  {31'b0, in_ready},  32'd1);
    chk({tag, ".alu_op"},    {28'b0, alu_op},    32'd0);
    chk({tag, ".op_a"},      op_a,               32'd0);
    chk({tag, ".op_b"},      op_b,               32'd0);
    chk({tag, ".illegal"},   {31'b0, illegal},   32'd0);
    chk({tag, ".br_negate"}, {31'b0, br_negate}, 32'd0);
  endtask

  initial begin
    vec[0]  = '{"add",     32'h002081B3, 32'h0,   32'd5,        32'd7, 4'b0000, 32'd5,        32'd7,        1'b0, 1'b0};
    vec[1]  = '{"sub",     32'h402081B3, 32'h0,   32'd10,       32'd3, 4'b1000, 32'd10,       32'd3,        1'b0, 1'b0};
    vec[2]  = '{"srai",    32'h4040D193, 32'h0,   32'h80000000, 32'd9, 4'b1101, 32'h80000000, 32'd4,        1'b0, 1'b0};
    vec[3]  = '{"lui",     32'h123452B7, 32'h0,   32'd55,       32'd9, 4'b0000, 32'd0,        32'h12345000, 1'b0, 1'b0};
    vec[4]  = '{"addi-1",  32'hFFF00093, 32'h0,   32'h11,       32'd9, 4'b0000, 32'h11,       32'hFFFFFFFF, 1'b0, 1'b0};
    vec[5]  = '{"allones", 32'hFFFFFFFF, 32'h0,   32'd5,        32'd7, 4'b0000, 32'd0,        32'd0,        1'b1, 1'b0};
    vec[6]  = '{"auipc",   32'h00001097, 32'h100, 32'd5,        32'd7, 4'b0000, 32'h100,      32'h1000,     1'b0, 1'b0};
    vec[7]  = '{"lw",      32'hFFC12083, 32'h0,   32'h1000,     32'd7, 4'b0000, 32'h1000,     32'hFFFFFFFC, 1'b0, 1'b0};
    vec[8]  = '{"sw",      32'hFE20AC23, 32'h0,   32'h2000,     32'd7, 4'b0000, 32'h2000,     32'hFFFFFFF8, 1'b0, 1'b0};
    vec[9]  = '{"slli_f7", 32'h41F09093, 32'h0,   32'd5,        32'd7, 4'b0000, 32'd0,        32'd0,        1'b1, 1'b0};
    vec[10] = '{"slli",    32'h01F09093, 32'h0,   32'd5,        32'd7, 4'b0001, 32'd5,        32'd31,       1'b0, 1'b0};
    vec[11] = '{"or_f7",   32'h4020E1B3, 32'h0,   32'd5,        32'd7, 4'b0000, 32'd0,        32'd0,        1'b1, 1'b0};
    vec[12] = '{"sltiu",   32'hFFF0B193, 32'h0,   32'd3,        32'd7, 4'b0011, 32'd3,        32'hFFFFFFFF, 1'b0, 1'b0};
    vec[13] = '{"addi_b30",32'h40008093, 32'h0,   32'd1,        32'd7, 4'b0000, 32'd1,        32'h400,      1'b0, 1'b0};
`ifdef ALU_ISSUE_BRANCH_EN
    vec[14] = '{"bge",     32'h0020D063, 32'h0,   32'd5,        32'd7, 4'b0010, 32'd5,        32'd7,        1'b0, 1'b1};
    vec[15] = '{"beq",     32'h00208063, 32'h0,   32'd5,        32'd7, 4'b1000, 32'd5,        32'd7,        1'b0, 1'b1};
`else
    vec[14] = '{"bge",     32'h0020D063, 32'h0,   32'd5,        32'd7, 4'b0000, 32'd0,        32'd0,        1'b1, 1'b0};
    vec[15] = '{"beq",     32'h00208063, 32'h0,   32'd5,        32'd7, 4'b0000, 32'd0,        32'd0,        1'b1, 1'b0};
`endif

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // back-to-back stream, one result per cycle
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, vec[i].instr, vec[i].pc, vec[i].rs1, vec[i].rs2);
      @(posedge clk);
      #1;
      chk({vec[i].name, ".out_valid"}, {31'b0, out_valid}, 32'd1);
      chk({vec[i].name, ".alu_op"},    {28'b0, alu_op},    {28'b0, vec[i].op});
      chk({vec[i].name, ".op_a"},      op_a,               vec[i].a);
      chk({vec[i].name, ".op_b"},      op_b,               vec[i].b);
      chk({vec[i].name, ".illegal"},   {31'b0, illegal},   {31'b0, vec[i].ill});
      chk({vec[i].name, ".br_negate"}, {31'b0, br_negate}, {31'b0, vec[i].neg});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_end.out_valid", {31'b0, out_valid}, 32'd0);

    // backpressure: A held, B into skid, C refused until skid drains
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h0, 32'hA, 32'h1);
    @(posedge clk);
    #1;
    chk("bp.A.op_a", op_a, 32'hA);
    chk("bp.A.in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h0, 32'hB, 32'h2);
    @(posedge clk);
    #1;
    chk("bp.B.in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp.B.hold_a", op_a, 32'hA);
    chk("bp.B.out_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h0, 32'hC, 32'h3);
    @(posedge clk);
    #1;
    chk("bp.C.hold_a", op_a, 32'hA);
    chk("bp.C.in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.deliver_b", op_a, 32'hB);
    chk("bp.deliver_b.op_b", op_b, 32'h2);
    chk("bp.reopen", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp.deliver_c", op_a, 32'hC);
    chk("bp.deliver_c.valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp.no_dup", {31'b0, out_valid}, 32'd0);

    // asynchronous reset with main and skid both occupied
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h402081B3, 32'h0, 32'h33, 32'h44);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 32'h402081B3, 32'h0, 32'h55, 32'h66);
    @(posedge clk);
    #1;
    chk("rst.pre.skid_full", {31'b0, in_ready}, 32'd0);
    chk("rst.pre.out_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.no_replay", {31'b0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU interface: decode stage that turns an RV32I instruction plus register-file read data into the ALU's ALUOp, operand A and operand B.
- Registers the results for the execute stage, behind a valid/ready handshake with a 2-entry skid buffer.
- Sits between register-file read and the execute-stage ALU. Sustains one instruction per cycle under no backpressure.

Parameters:
- XLEN, 32, datapath width; only 32 is supported, and elaboration fails otherwise.
- ZERO_ILLEGAL, 1, when 1, op_a/op_b are driven 0 for illegal instructions; when 0, they carry rs1_data/rs2_data.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept; registered
- instr  input  32  instruction word
- pc  input  XLEN  instruction address
- rs1_data  input  XLEN  rs1 read value
- rs2_data  input  XLEN  rs2 read value
- out_valid  output  1  payload valid toward the ALU
- out_ready  input  1  execute stage accepts
- alu_op  output  4  ALUOp: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111
- op_a  output  XLEN  ALU operand A
- op_b  output  XLEN  ALU operand B
- illegal  output  1  instruction not decodable
- br_negate  output  1  branch condition is the inverse of the ALU result (see Optional Feature)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, in_ready=1, alu_op=0, op_a=0, op_b=0, illegal=0, br_negate=0.
  - Both buffer entries are emptied.
  - In-flight payloads are discarded; no replay.
- Handshake:
  - A transfer occurs on a rising edge where valid&&ready.
  - Latency is 1 cycle from input acceptance to out_valid.
  - The output payload is stable while out_valid&&!out_ready.
  - out_valid never drops without a transfer.
- Skid buffer (two entries: main and skid):
  - Input accepted while main is full and not draining: goes to skid.
  - in_ready = !skid_full. It deasserts the cycle after skid fills and reasserts the cycle after skid empties.
  - Simultaneous accept and drain with skid empty: main reloads directly.
  - With skid full, a drain moves skid into main.
  - Strict FIFO order; no loss or duplication.
- Decode is combinational on the input side and registered with the payload. opcode=instr[6:0], f3=instr[14:12], b30=instr[30].
  - OP 0110011:
    - op_a=rs1, op_b=rs2, alu_op={b30,f3}.
    - Legal only if funct7 is 0000000, or 0100000 with f3 in {000,101}.
  - OP-IMM 0010011:
    - op_a=rs1, op_b=sign-extended instr[31:20].
    - alu_op={f3==101 ? b30 : 0, f3}.
    - SLLI/SRLI/SRAI: op_b=zero-extended instr[24:20]. funct7 must be 0000000, or 0100000 only with f3=101.
  - LUI 0110111: op_a=0, op_b={instr[31:12],12'b0}, ADD.
  - AUIPC 0010111: op_a=pc, op_b=U-immediate, ADD.
  - LOAD 0000011: op_a=rs1, op_b=I-immediate, ADD (address generation).
  - STORE 0100011: op_a=rs1, op_b=S-immediate {instr[31:25],instr[11:7]} sign-extended, ADD.
  - Anything else:
    - illegal=1, alu_op=0000.
    - Operands per ZERO_ILLEGAL.
    - Still transferred like any other payload, never dropped.
- br_negate=0 for all non-branch payloads.

Optional Feature:
- Macro ALU_ISSUE_BRANCH_EN.
- Defined: BRANCH 1100011 decodes with op_a=rs1, op_b=rs2.
  - BEQ/BNE: SUB.
  - BLT/BGE: SLT.
  - BLTU/BGEU: SLTU.
  - br_negate=1 for BEQ, BGE and BGEU (taken when the ALU result is zero). f3 010/011 is illegal.
- Undefined: BRANCH is illegal, and br_negate is tied 0.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum (4-bit ALUOp encodings above).
  - Opcode localparams OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH.
  - Packed struct issue_payload_t {alu_op, op_a, op_b, illegal, br_negate}.
- The ALU imports the same enum.
- One sub-module, skid_buffer: generic 2-entry valid/ready buffer parameterised on payload type. Decode stays in alu_issue_stage.

Test Plan:
- instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_op=0000, op_a=5, op_b=7, illegal=0.
- instr=0x402081B3 (sub) -> alu_op=1000; instr=0x4040D193 (srai x3,x1,4) -> alu_op=1101, op_b=4.
- instr=0x123452B7 (lui) -> op_a=0, op_b=0x12345000, alu_op=0000.
- instr=0xFFF00093 (addi x1,x0,-1) -> op_b=0xFFFFFFFF. instr=0xFFFFFFFF -> illegal=1, alu_op=0000, op_a=op_b=0.
- out_ready=0, three back-to-back inputs A,B,C:
  - A held on the outputs, B accepted into skid, in_ready=0 the following cycle, C not accepted.
  - out_ready=1 -> A,B,C delivered in order, none lost or duplicated.
- rst pulsed mid-cycle with out_valid=1 and skid full -> out_valid=0 and in_ready=1 immediately; outputs zero.
- With ALU_ISSUE_BRANCH_EN, bge x1,x2 -> alu_op=0010, br_negate=1.
